// File: rtl/blink_meter.sv
// blink_meter: measures period, high time and rise phase of an async blink input
// against the shared currentCount timebase. Optional lock detect: BLINK_METER_LOCK_EN.
module blink_meter #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             blink_in,
    input  logic [WIDTH-1:0] currentCount,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic [WIDTH-1:0] offset,
    output logic             valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync_pipe;
    logic                   sync_q, prev, rise, fall;
    logic [WIDTH-1:0]       cnt, high_shadow;
    logic                   arm, shadow_ld, publish, to_evt;

    assign sync_q = sync_pipe[SYNC_STAGES-1];
    assign rise   = sync_q & ~prev;
    assign fall   = ~sync_q & prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_pipe <= '0;
            prev      <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], blink_in};
            prev      <= sync_q;
        end
    end

    // Free-running saturating counter, restarted at 1 on every rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              cnt <= '0;
        else if (rise)           cnt <= CNT_ONE;
        else if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        arm       = 1'b0;
        shadow_ld = 1'b0;
        publish   = 1'b0;
        to_evt    = 1'b0;
        case (state)
            IDLE: if (rise) begin
                arm       = 1'b1;
                state_nxt = HIGH;
            end
            // A rise here cannot occur once synchronized, so only fall/saturation matter.
            HIGH: if (cnt == CNT_MAX) begin
                to_evt    = 1'b1;
                state_nxt = IDLE;
            end else if (fall) begin
                shadow_ld = 1'b1;
                state_nxt = LOW;
            end
            // Rise takes priority over saturation: publishes a full-scale period.
            LOW: if (rise) begin
                publish   = 1'b1;
                state_nxt = HIGH;
            end else if (cnt == CNT_MAX) begin
                to_evt    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) high_shadow <= '0;
        else if (shadow_ld) high_shadow <= cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period    <= '0;
            high_time <= '0;
            offset    <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (publish) begin
                period    <= cnt;
                high_time <= high_shadow;
                offset    <= currentCount;
                valid     <= 1'b1;
                timeout   <= 1'b0;
            end else if (arm) begin
                offset  <= currentCount;
                timeout <= 1'b0;
            end else if (to_evt) begin
                timeout <= 1'b1;
            end
        end
    end

`ifdef BLINK_METER_LOCK_EN
    // The published registers double as the previous measurement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       locked <= 1'b0;
        else if (publish) locked <= (cnt == period) && (high_shadow == high_time);
        else if (to_evt)  locked <= 1'b0;
    end
`else
    assign locked = 1'b0;
`endif

endmodule
